lsu_writeback: RTL and testbench

//  Load/store + writeback stage directly upstream of the register file write port.

---
 rtl/lsu_writeback_pkg.sv | 45 ++++
 rtl/lsu_writeback_align.sv | 112 +++++++++++
 rtl/lsu_writeback.sv | 258 +++++++++++++++++++++++++
 tb/tb_lsu_writeback.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_writeback_pkg.sv
// -----------------------------------------------------------------------------
// lsu_writeback_pkg
// Shared definitions for the load/store + writeback stage:
//   - op kind codes carried on in_kind
//   - RV32I load/store funct3 encodings
//   - FSM state encoding of lsu_writeback
//   - access-size misalignment helper
// -----------------------------------------------------------------------------
package lsu_writeback_pkg;

    typedef enum logic [1:0] {
        KIND_ALU   = 2'b00,
        KIND_LOAD  = 2'b01,
        KIND_STORE = 2'b10,
        KIND_RSVD  = 2'b11
    } kind_e;

    // RV32I funct3 encodings; bits [1:0] give log2 of the access size,
    // bit 2 selects zero-extension on loads.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_WB   = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    // Misaligned when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_writeback_align.sv
// -----------------------------------------------------------------------------
// lsu_writeback_align
// Purely combinational data-path helper for lsu_writeback.
//   Decode side (driven from the incoming op):
//     i_kind, i_funct3, i_addr_lo, i_sdata -> o_bad (misaligned or illegal),
//     o_wstrb / o_wdata (store byte enables and lane-replicated store data)
//   Load side (driven from the captured op):
//     i_ld_funct3, i_ld_addr_lo, i_rdata -> o_ld_data (lane extracted, extended)
// -----------------------------------------------------------------------------
module lsu_writeback_align
    import lsu_writeback_pkg::*;
(
    input  logic [1:0]  i_kind,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_sdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_rdata,
    output logic        o_bad,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    logic       w_illegal;
    logic       w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Illegal kind / funct3 detection
    always_comb begin
        w_illegal = 1'b0;
        case (i_kind)
            KIND_ALU: begin
                w_illegal = 1'b0;
            end
            KIND_LOAD: begin
                case (i_funct3)
                    F3_B, F3_H, F3_W, F3_BU, F3_HU: w_illegal = 1'b0;
                    default:                        w_illegal = 1'b1;
                endcase
            end
            KIND_STORE: begin
                case (i_funct3)
                    F3_B, F3_H, F3_W: w_illegal = 1'b0;
                    default:          w_illegal = 1'b1;
                endcase
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Misalignment only matters for memory ops
    always_comb begin
        w_misaligned = 1'b0;
        if ((i_kind == KIND_LOAD) || (i_kind == KIND_STORE)) begin
            w_misaligned = is_misaligned(i_funct3, i_addr_lo);
        end else begin
            w_misaligned = 1'b0;
        end
    end

    assign o_bad = w_illegal | w_misaligned;

    // Store byte enables and lane replication
    always_comb begin
        o_wstrb = 4'b0000;
        o_wdata = 32'h0000_0000;
        case (i_funct3[1:0])
            2'b00: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_sdata[7:0]}};
            end
            2'b01: begin
                o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_sdata[15:0]}};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_sdata;
            end
        endcase
    end

    // Byte / halfword lane selection for loads
    always_comb begin
        w_byte = 8'h00;
        case (i_ld_addr_lo)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Load sign / zero extension
    always_comb begin
        o_ld_data = 32'h0000_0000;
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data = {24'h00_0000, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {16'h0000, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_writeback.sv
// -----------------------------------------------------------------------------
// lsu_writeback
// Load/store + writeback stage feeding the register file write port.
// Takes one executed op at a time (ALU result, load or store), runs the
// data-memory request/grant/rvalid handshake, aligns and extends load data,
// and drives a registered register-file write that is stable for a whole
// cycle (the register file writes on the negedge).
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready          upstream handshake; ready only in IDLE
//   in_kind/in_funct3          op kind (ALU/LOAD/STORE/rsvd) and RV32I funct3
//   in_addr/in_data/in_rd      byte address, ALU result or store data, dest reg
//   mem_req/mem_we/mem_addr    memory request, held until mem_gnt
//   mem_wdata/mem_wstrb        replicated store data and byte enables
//   mem_gnt/mem_rvalid/mem_rdata  memory grant, load data valid, load data
//   rf_should_write/rf_write_addr/rf_write_data  register file write
//   err                        one-cycle pulse: misaligned, illegal or timeout
// -----------------------------------------------------------------------------
module lsu_writeback
    import lsu_writeback_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [4:0]  in_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_should_write,
    output logic [4:0]  rf_write_addr,
    output logic [31:0] rf_write_data,
    output logic        err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e      r_state;
    state_e      w_state_nx;

    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [4:0]  r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic        r_rf_we;
    logic [4:0]  r_rf_addr;
    logic [31:0] r_rf_data;
    logic        r_err;

    logic        w_accept;
    logic        w_bad;
    logic        w_is_store;
    logic [3:0]  w_st_wstrb;
    logic [31:0] w_st_wdata;
    logic [31:0] w_ld_data;
    logic [4:0]  w_wb_rd;
    logic [31:0] w_wb_data;
    logic        w_to_wb;

    assign in_ready   = (r_state == ST_IDLE);
    assign w_accept   = in_valid & in_ready;
    assign w_is_store = (in_kind == KIND_STORE);

    lsu_writeback_align u_align (
        .i_kind       (in_kind),
        .i_funct3     (in_funct3),
        .i_addr_lo    (in_addr[1:0]),
        .i_sdata      (in_data),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_addr_lo),
        .i_rdata      (mem_rdata),
        .o_bad        (w_bad),
        .o_wstrb      (w_st_wstrb),
        .o_wdata      (w_st_wdata),
        .o_ld_data    (w_ld_data)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_bad) begin
                        w_state_nx = ST_ERR;
                    end else if (in_kind == KIND_ALU) begin
                        w_state_nx = ST_WB;
                    end else begin
                        w_state_nx = ST_REQ;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    if (r_mem_we) begin
                        w_state_nx = ST_IDLE;
                    end else if (mem_rvalid) begin
                        w_state_nx = ST_WB;
                    end else begin
                        w_state_nx = ST_WAIT;
                    end
                end else begin
                    w_state_nx = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    w_state_nx = ST_WB;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nx = ST_ERR;
                end else begin
                    w_state_nx = ST_WAIT;
                end
            end
            ST_WB:   w_state_nx = ST_IDLE;
            ST_ERR:  w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Writeback source: ALU result straight from the input at accept,
    // otherwise the extracted load word from the captured op
    always_comb begin
        w_to_wb   = (w_state_nx == ST_WB);
        w_wb_rd   = r_rd;
        w_wb_data = w_ld_data;
        if (r_state == ST_IDLE) begin
            w_wb_rd   = in_rd;
            w_wb_data = in_data;
        end else begin
            w_wb_rd   = r_rd;
            w_wb_data = w_ld_data;
        end
    end

    // Captured op fields needed after accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_funct3  <= 3'b000;
            r_addr_lo <= 2'b00;
            r_rd      <= 5'd0;
        end else if (w_accept) begin
            r_funct3  <= in_funct3;
            r_addr_lo <= in_addr[1:0];
            r_rd      <= in_rd;
        end else begin
            r_funct3  <= r_funct3;
            r_addr_lo <= r_addr_lo;
            r_rd      <= r_rd;
        end
    end

    // Memory request registers: loaded at accept, request released on grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_wdata <= 32'h0000_0000;
            r_mem_wstrb <= 4'b0000;
        end else if (w_accept && (w_state_nx == ST_REQ)) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_is_store;
            r_mem_addr  <= {in_addr[31:2], 2'b00};
            r_mem_wdata <= w_is_store ? w_st_wdata : 32'h0000_0000;
            r_mem_wstrb <= w_is_store ? w_st_wstrb : 4'b0000;
        end else if ((r_state == ST_REQ) && mem_gnt) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= r_mem_addr;
            r_mem_wdata <= r_mem_wdata;
            r_mem_wstrb <= 4'b0000;
        end else begin
            r_mem_req   <= r_mem_req;
            r_mem_we    <= r_mem_we;
            r_mem_addr  <= r_mem_addr;
            r_mem_wdata <= r_mem_wdata;
            r_mem_wstrb <= r_mem_wstrb;
        end
    end

    // Load-response timeout counter, only runs while in WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((r_state == ST_WAIT) && (w_state_nx == ST_WAIT)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= '0;
        end
    end

    // Register file write: enable lives exactly for the WB state; x0 is never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rf_we   <= 1'b0;
            r_rf_addr <= 5'd0;
            r_rf_data <= 32'h0000_0000;
        end else if (w_to_wb) begin
            r_rf_we   <= (w_wb_rd != 5'd0);
            r_rf_addr <= w_wb_rd;
            r_rf_data <= w_wb_data;
        end else begin
            r_rf_we   <= 1'b0;
            r_rf_addr <= r_rf_addr;
            r_rf_data <= r_rf_data;
        end
    end

    // Error pulse lives exactly for the ERR state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_state_nx == ST_ERR);
        end
    end

    assign mem_req         = r_mem_req;
    assign mem_we          = r_mem_we;
    assign mem_addr        = r_mem_addr;
    assign mem_wdata       = r_mem_wdata;
    assign mem_wstrb       = r_mem_wstrb;
    assign rf_should_write = r_rf_we;
    assign rf_write_addr   = r_rf_addr;
    assign rf_write_data   = r_rf_data;
    assign err             = r_err;

endmodule

// File: tb/tb_lsu_writeback.sv
// -----------------------------------------------------------------------------
// tb_lsu_writeback
// Self-checking bench for lsu_writeback: directed cases followed by random
// ops, each compared against a transaction-level reference model of the
// stage (op classification, expected memory fields, expected writeback).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_lsu_writeback;

    localparam int TO = 255;
    localparam int CLS_ALU = 0, CLS_LOAD = 1, CLS_STORE = 2, CLS_ERR = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [1:0]  in_kind;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_data;
    logic [4:0]  in_rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        rf_should_write, err;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_wb;
    logic        last_err;

    always #5 clk = ~clk;

    lsu_writeback #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_data(in_data), .in_rd(in_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_should_write(rf_should_write), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .err(err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: classify the op and derive the memory / writeback values
    function automatic void model(input logic [1:0] kind, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] data,
                                  input logic [31:0] rdata, output int cls,
                                  output logic [3:0] strb, output logic [31:0] wdat,
                                  output logic [31:0] ld);
        int nbytes, off;
        logic legal;
        logic [31:0] sh, mask;
        nbytes = 1 << f3[1:0];
        off    = int'(addr % 32'd4);
        if (kind == 2'd1)      legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        else if (kind == 2'd2) legal = (f3 <= 3'd2);
        else                   legal = (kind == 2'd0);
        if (!legal)                                cls = CLS_ERR;
        else if (kind == 2'd0)                     cls = CLS_ALU;
        else if ((off % nbytes) != 0)              cls = CLS_ERR;
        else                                       cls = (kind == 2'd1) ? CLS_LOAD : CLS_STORE;
        strb = 4'b0000; wdat = 32'h0; ld = 32'h0;
        if (cls == CLS_LOAD || cls == CLS_STORE) begin
            strb = 4'(((1 << nbytes) - 1) << off);
            for (int b = 0; b < 4; b++) wdat[8*b +: 8] = data[8*(b % nbytes) +: 8];
            sh = rdata >> (8 * off);
            if (nbytes == 4) ld = sh;
            else begin
                mask = (32'd1 << (8 * nbytes)) - 32'd1;
                ld = sh & mask;
                if (!f3[2] && sh[8*nbytes-1]) ld = ld | ~mask;
            end
        end
    endfunction

    // Drive one op from IDLE and follow it to completion, checking every step.
    // rv_dly: 0 = rvalid with grant; n>0 = rvalid in WAIT cycle n-1 (beyond TO means never)
    task automatic run_op(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rd,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        int cls;
        logic [3:0]  e_strb;
        logic [31:0] e_wdat, e_ld;
        logic got_rv;
        model(kind, f3, addr, data, rdata, cls, e_strb, e_wdat, e_ld);
        last_err = 1'b0;
        check_eq("ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_kind = kind; in_funct3 = f3; in_addr = addr; in_data = data; in_rd = rd;
        step();
        in_valid = 1'b0; in_kind = 2'($urandom); in_funct3 = 3'($urandom);
        in_addr = $urandom; in_data = $urandom; in_rd = 5'($urandom);
        if (cls == CLS_ALU || cls == CLS_ERR) begin
            mem_rvalid = 1'($urandom);
            mem_rdata  = $urandom;
            check_eq("no_req", 32'(mem_req), 32'd0);
            check_eq("ready_busy", 32'(in_ready), 32'd0);
            if (cls == CLS_ALU) begin
                check_eq("alu_we", 32'(rf_should_write), 32'(rd != 5'd0));
                check_eq("alu_err", 32'(err), 32'd0);
                if (rd != 5'd0) begin
                    check_eq("alu_addr", 32'(rf_write_addr), 32'(rd));
                    check_eq("alu_data", rf_write_data, data);
                end
                last_wb = rf_write_data;
            end else begin
                check_eq("err_pulse", 32'(err), 32'd1);
                check_eq("err_no_we", 32'(rf_should_write), 32'd0);
                last_err = err;
            end
            step();
            mem_rvalid = 1'b0;
            check_eq("one_cycle_we", 32'(rf_should_write), 32'd0);
            check_eq("one_cycle_err", 32'(err), 32'd0);
            check_eq("ready_back", 32'(in_ready), 32'd1);
        end else begin
            for (int i = 0; i <= gnt_dly; i++) begin
                check_eq("req_held", 32'(mem_req), 32'd1);
                check_eq("req_addr", mem_addr, {addr[31:2], 2'b00});
                check_eq("req_we", 32'(mem_we), 32'(cls == CLS_STORE));
                check_eq("req_strb", 32'(mem_wstrb), (cls == CLS_STORE) ? 32'(e_strb) : 32'd0);
                if (cls == CLS_STORE) check_eq("req_wdata", mem_wdata, e_wdat);
                check_eq("req_ready", 32'(in_ready), 32'd0);
                mem_gnt    = (i == gnt_dly);
                mem_rvalid = (cls == CLS_LOAD) && (i == gnt_dly) && (rv_dly == 0);
                mem_rdata  = mem_rvalid ? rdata : $urandom;
                step();
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            check_eq("req_drop", 32'(mem_req), 32'd0);
            if (cls == CLS_STORE) begin
                check_eq("st_no_we", 32'(rf_should_write), 32'd0);
                check_eq("st_ready", 32'(in_ready), 32'd1);
                check_eq("st_err", 32'(err), 32'd0);
            end else begin
                got_rv = (rv_dly == 0);
                for (int k = 0; k < TO && !got_rv; k++) begin
                    mem_rvalid = (k == rv_dly - 1);
                    mem_rdata  = mem_rvalid ? rdata : $urandom;
                    got_rv     = mem_rvalid;
                    step();
                end
                mem_rvalid = 1'b0;
                if (got_rv) begin
                    check_eq("ld_we", 32'(rf_should_write), 32'(rd != 5'd0));
                    check_eq("ld_err", 32'(err), 32'd0);
                    if (rd != 5'd0) begin
                        check_eq("ld_addr", 32'(rf_write_addr), 32'(rd));
                        check_eq("ld_data", rf_write_data, e_ld);
                    end
                    last_wb = rf_write_data;
                    step();
                    check_eq("ld_one_cycle", 32'(rf_should_write), 32'd0);
                    check_eq("ld_ready", 32'(in_ready), 32'd1);
                end else begin
                    check_eq("to_err", 32'(err), 32'd1);
                    check_eq("to_no_we", 32'(rf_should_write), 32'd0);
                    last_err = err;
                    mem_rvalid = 1'b1; mem_rdata = $urandom;
                    step();
                    check_eq("to_err_1cyc", 32'(err), 32'd0);
                    check_eq("late_rv_we", 32'(rf_should_write), 32'd0);
                    check_eq("to_ready", 32'(in_ready), 32'd1);
                    step();
                    mem_rvalid = 1'b0;
                    check_eq("late_rv_we2", 32'(rf_should_write), 32'd0);
                    check_eq("late_rv_ready", 32'(in_ready), 32'd1);
                end
            end
        end
    endtask

    initial begin
        int r, gd, rv;
        logic [1:0]  k;
        logic [2:0]  f;
        logic [2:0]  legal_f3 [5];
        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
        legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
        reset = 1'b1; in_valid = 1'b0; in_kind = 2'd0; in_funct3 = 3'd0;
        in_addr = 32'h0; in_data = 32'h0; in_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        last_wb = 32'h0; last_err = 1'b0;
        step(); step();
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_we", 32'(rf_should_write), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_wdata", rf_write_data, 32'd0);
        check_eq("rst_strb", 32'(mem_wstrb), 32'd0);
        reset = 1'b0;
        step();
        check_eq("rst_ready", 32'(in_ready), 32'd1);

        // Directed cases
        run_op(2'd0, 3'd0, 32'h0, 32'hDEADBEEF, 5'd5, 0, 0, 32'h0);
        check_eq("dir_alu", last_wb, 32'hDEADBEEF);
        run_op(2'd1, 3'd0, 32'h1003, 32'h0, 5'd7, 1, 0, 32'h80FF_FF7F);
        check_eq("dir_lb", last_wb, 32'hFFFF_FF80);
        run_op(2'd1, 3'd4, 32'h1003, 32'h0, 5'd7, 0, 2, 32'h80FF_FF7F);
        check_eq("dir_lbu", last_wb, 32'h0000_0080);
        run_op(2'd2, 3'd1, 32'h2002, 32'h0000_ABCD, 5'd3, 3, 0, 32'h0);
        run_op(2'd1, 3'd2, 32'h3001, 32'h0, 5'd9, 0, 0, 32'h0);
        check_eq("dir_lw_mis", 32'(last_err), 32'd1);
        run_op(2'd1, 3'd2, 32'h3000, 32'h0, 5'd0, 0, 1, 32'h1234_5678);
        run_op(2'd1, 3'd5, 32'h4002, 32'h0, 5'd12, 0, TO, 32'h8001_0002);
        check_eq("dir_lhu_last", last_wb, 32'h0000_8001);
        run_op(2'd1, 3'd2, 32'h5000, 32'h0, 5'd4, 0, TO + 1, 32'h0);
        check_eq("dir_timeout", 32'(last_err), 32'd1);
        run_op(2'd3, 3'd0, 32'h0, 32'h0, 5'd1, 0, 0, 32'h0);
        run_op(2'd2, 3'd3, 32'h0, 32'h0, 5'd1, 0, 0, 32'h0);

        // Random ops
        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 19));
            k = (r < 5) ? 2'd0 : (r < 12) ? 2'd1 : (r < 18) ? 2'd2 : 2'd3;
            f = ($urandom_range(0, 4) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
            gd = int'($urandom_range(0, 3));
            rv = ($urandom_range(0, 40) == 0) ? TO + 1 : int'($urandom_range(0, 4));
            run_op(k, f, $urandom, $urandom, 5'($urandom), gd, rv, $urandom);
        end

        // Reset while REQ is waiting for grant
        in_valid = 1'b1; in_kind = 2'd1; in_funct3 = 3'd2; in_addr = 32'h6000; in_rd = 5'd8;
        step();
        in_valid = 1'b0;
        check_eq("pre_rst_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_req_drop", 32'(mem_req), 32'd0);
        check_eq("rst_req_ready", 32'(in_ready), 32'd1);
        #2 reset = 1'b0;
        step();
        check_eq("post_rst_ready", 32'(in_ready), 32'd1);

        // Reset while in WAIT, then a late rvalid must not write back
        in_valid = 1'b1; in_kind = 2'd1; in_funct3 = 3'd2; in_addr = 32'h7000; in_rd = 5'd9;
        step();
        in_valid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        check_eq("wait_busy", 32'(in_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_wait_req", 32'(mem_req), 32'd0);
        check_eq("rst_wait_we", 32'(rf_should_write), 32'd0);
        check_eq("rst_wait_err", 32'(err), 32'd0);
        #2 reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        check_eq("rst_late_ready", 32'(in_ready), 32'd1);
        step();
        mem_rvalid = 1'b0;
        check_eq("rst_late_we", 32'(rf_should_write), 32'd0);
        check_eq("rst_late_err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
